// File: rtl/fpu_f32_pkg.sv
// Shared FP32 definitions for the multiplier issue stage.
//   f32_t               : sign/exponent/mantissa view of an IEEE-754 single
//   F32_QNAN / F32_INF  : canonical quiet NaN and +infinity encodings
//   f32_classify()      : {is_zero, is_inf, is_nan} of one operand
//   f32_mul_special()   : {bypass, value} for operand pairs whose product
//                         is fixed by the special-value rules (NaN/inf/zero)
package fpu_f32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } f32_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } f32_class_t;

    localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] F32_INF  = 32'h7F80_0000;

    function automatic f32_class_t f32_classify(input f32_t x);
        f32_class_t c;
        c.is_zero = (x.exp == 8'h00) && (x.mant == 23'd0);
        c.is_inf  = (x.exp == 8'hFF) && (x.mant == 23'd0);
        c.is_nan  = (x.exp == 8'hFF) && (x.mant != 23'd0);
        return c;
    endfunction

    // Denormals classify as neither zero nor inf, so they fall through to
    // the real multiplier unless the other operand forces the result.
    function automatic logic [32:0] f32_mul_special(input f32_t a, input f32_t b);
        f32_class_t ca;
        f32_class_t cb;
        logic       s;
        ca = f32_classify(a);
        cb = f32_classify(b);
        s  = a.sign ^ b.sign;
        if (ca.is_nan || cb.is_nan)
            return {1'b1, F32_QNAN};
        if ((ca.is_inf && cb.is_zero) || (ca.is_zero && cb.is_inf))
            return {1'b1, F32_QNAN};
        if (ca.is_inf || cb.is_inf)
            return {1'b1, s, F32_INF[30:0]};
        if (ca.is_zero || cb.is_zero)
            return {1'b1, s, 31'd0};
        return {1'b0, 32'd0};
    endfunction

endpackage

// File: rtl/fpu_f32_mul_result_fifo.sv
// First-word-fall-through result FIFO for the FP32 multiplier issue stage.
// Ports:
//   CLK, nRST        : clock, synchronous active-low reset
//   wr_en, wr_data   : push one entry (ignored when full)
//   rd_en            : pop the head (ignored when empty)
//   rd_data          : current head, forced to zero while empty
//   empty            : no entry present
// Pointers carry one extra MSB so full and empty are distinguishable when
// the index bits are equal.
module fpu_f32_mul_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 36
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Zeroing the head while empty keeps stale memory off the outputs,
    // including straight after reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fpu_f32_mul_issue.sv
// Issue / result-return stage around the FP32 multiplier datapath.
// Ports:
//   CLK, nRST                     : clock, synchronous active-low reset
//   REQ_VALID/REQ_READY           : request handshake
//   REQ_A, REQ_B, REQ_TAG         : operands and tag
//   MUL_A, MUL_B                  : registered operands to the multiplier
//   MUL_O                         : multiplier result (LATENCY cycles after MUL_A/B)
//   RES_VALID/RES_READY           : result handshake (FIFO head)
//   RES_O, RES_TAG                : result and its tag
// Build option: FPU_F32_MUL_SPECIAL_BYPASS_EN classifies operands on accept
// and substitutes the fixed NaN/inf/zero result for MUL_O when sampling.
module fpu_f32_mul_issue
    import fpu_f32_pkg::*;
#(
    parameter int LATENCY    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [31:0]      REQ_A,
    input  logic [31:0]      REQ_B,
    input  logic [TAG_W-1:0] REQ_TAG,
    output logic [31:0]      MUL_A,
    output logic [31:0]      MUL_B,
    input  logic [31:0]      MUL_O,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [31:0]      RES_O,
    output logic [TAG_W-1:0] RES_TAG
);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    logic [OW-1:0]             outstanding_q, outstanding_d;
    logic [31:0]               mul_a_q, mul_a_d;
    logic [31:0]               mul_b_q, mul_b_d;
    logic [LATENCY:0]          vld_q, vld_d;
    logic [LATENCY:0][TAG_W-1:0] tag_q, tag_d;
    logic                      accept;
    logic                      pop;
    logic                      fifo_empty;
    logic [31:0]               sample_val;

    // Counting in-flight ops together with buffered results means an
    // accepted op always has a FIFO slot reserved, so no overflow path exists.
    assign REQ_READY = nRST & (outstanding_q < OW'(FIFO_DEPTH));
    assign accept    = REQ_VALID & REQ_READY;
    assign pop       = RES_VALID & RES_READY;
    assign MUL_A     = mul_a_q;
    assign MUL_B     = mul_b_q;
    assign RES_VALID = !fifo_empty;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        mul_a_d = accept ? REQ_A : mul_a_q;
        mul_b_d = accept ? REQ_B : mul_b_q;

        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = accept;
        tag_d[0] = REQ_TAG;
        for (int i = 1; i <= LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            outstanding_q <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            vld_q         <= '0;
            tag_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            vld_q         <= vld_d;
            tag_q         <= tag_d;
        end
    end

`ifdef FPU_F32_MUL_SPECIAL_BYPASS_EN
    logic [LATENCY:0]        byp_q, byp_d;
    logic [LATENCY:0][31:0]  byp_val_q, byp_val_d;
    logic [32:0]             special;

    assign special = f32_mul_special(f32_t'(REQ_A), f32_t'(REQ_B));

    always_comb begin
        byp_d        = '0;
        byp_val_d    = '0;
        byp_d[0]     = accept & special[32];
        byp_val_d[0] = special[31:0];
        for (int i = 1; i <= LATENCY; i++) begin
            byp_d[i]     = byp_q[i-1];
            byp_val_d[i] = byp_val_q[i-1];
        end
        sample_val = byp_q[LATENCY] ? byp_val_q[LATENCY] : MUL_O;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            byp_q     <= '0;
            byp_val_q <= '0;
        end else begin
            byp_q     <= byp_d;
            byp_val_q <= byp_val_d;
        end
    end
`else
    assign sample_val = MUL_O;
`endif

    fpu_f32_mul_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32 + TAG_W)
    ) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .wr_en   (vld_q[LATENCY]),
        .wr_data ({sample_val, tag_q[LATENCY]}),
        .rd_en   (pop),
        .rd_data ({RES_O, RES_TAG}),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_fpu_f32_mul_issue.sv
module tb_fpu_f32_mul_issue;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT 0: LATENCY = 0 ----------------
    logic        req_valid0 = 0, req_ready0, res_valid0, res_ready0 = 0;
    logic [31:0] req_a0 = 0, req_b0 = 0, mul_a0, mul_b0, mul_o0, res_o0;
    logic [3:0]  req_tag0 = 0, res_tag0;
    logic        force0 = 0;

    fpu_f32_mul_issue #(.LATENCY(0), .FIFO_DEPTH(4), .TAG_W(4)) u_dut0 (
        .CLK(clk), .nRST(n_rst),
        .REQ_VALID(req_valid0), .REQ_READY(req_ready0),
        .REQ_A(req_a0), .REQ_B(req_b0), .REQ_TAG(req_tag0),
        .MUL_A(mul_a0), .MUL_B(mul_b0), .MUL_O(mul_o0),
        .RES_VALID(res_valid0), .RES_READY(res_ready0),
        .RES_O(res_o0), .RES_TAG(res_tag0)
    );

    // ---------------- DUT 2: LATENCY = 2 ----------------
    logic        req_valid2 = 0, req_ready2, res_valid2, res_ready2 = 0;
    logic [31:0] req_a2 = 0, req_b2 = 0, mul_a2, mul_b2, mul_o2, res_o2;
    logic [3:0]  req_tag2 = 0, res_tag2;
    logic [31:0] pipe1 = 0, pipe2 = 0;

    fpu_f32_mul_issue #(.LATENCY(2), .FIFO_DEPTH(4), .TAG_W(4)) u_dut2 (
        .CLK(clk), .nRST(n_rst),
        .REQ_VALID(req_valid2), .REQ_READY(req_ready2),
        .REQ_A(req_a2), .REQ_B(req_b2), .REQ_TAG(req_tag2),
        .MUL_A(mul_a2), .MUL_B(mul_b2), .MUL_O(mul_o2),
        .RES_VALID(res_valid2), .RES_READY(res_ready2),
        .RES_O(res_o2), .RES_TAG(res_tag2)
    );

    // Stand-in multiplier: exact for normal operands whose product fits in
    // 24 mantissa bits (truncating otherwise), zero-aware.
    function automatic logic [31:0] f32_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
        return {s, e[7:0], p[45:23]};
    endfunction

    // Small positive integer to FP32, independent of the multiplier model.
    function automatic logic [31:0] int_f32(input int n);
        int          msb;
        logic [31:0] m;
        msb = 0;
        for (int i = 0; i < 31; i++) if (n >= (1 << i)) msb = i;
        m = 32'(n) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    assign mul_o0 = force0 ? 32'h1234_5678 : f32_mul(mul_a0, mul_b0);
    assign mul_o2 = pipe2;
    always @(posedge clk) begin
        pipe1 <= f32_mul(mul_a2, mul_b2);
        pipe2 <= pipe1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                          input string nm);
        int n;
        n = 0;
        req_valid0 = 1; req_a0 = a; req_b0 = b; req_tag0 = tag;
        while (!req_ready0 && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_ready"}, 64'(req_ready0), 64'd1);
        @(negedge clk);
        req_valid0 = 0;
    endtask

    task automatic pop0_expect(input logic [31:0] eo, input logic [3:0] et, input string nm);
        int n;
        n = 0;
        while (!res_valid0 && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, 64'(res_valid0), 64'd1);
        if (res_valid0) begin
            chk({nm, "_o"}, 64'(res_o0), 64'(eo));
            chk({nm, "_tag"}, 64'(res_tag0), 64'(et));
            res_ready0 = 1;
            @(negedge clk);
            res_ready0 = 0;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        int got;

        tbl[0] = '{32'h4040_0000, 32'h4000_0000, 4'd5,  32'h40C0_0000};
        tbl[1] = '{32'h3F80_0000, 32'h3F80_0000, 4'd1,  32'h3F80_0000};
        tbl[2] = '{32'hC000_0000, 32'h4040_0000, 4'd2,  32'hC0C0_0000};
        tbl[3] = '{32'h3FC0_0000, 32'h3FC0_0000, 4'd3,  32'h4010_0000};
        tbl[4] = '{32'h4120_0000, 32'h40A0_0000, 4'hF,  32'h4248_0000};

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready0), 64'd0);
        chk("rst_res_valid", 64'(res_valid0), 64'd0);
        chk("rst_res_o",     64'(res_o0),     64'd0);
        chk("rst_res_tag",   64'(res_tag0),   64'd0);
        chk("rst_mul_a",     64'(mul_a0),     64'd0);
        chk("rst_mul_b",     64'(mul_b0),     64'd0);
        n_rst = 1;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready0), 64'd1);

        // ---- table: single ops, LATENCY=0, RES_READY held high ----
        res_ready0 = 1;
        for (int v = 0; v < 5; v++) begin
            req_valid0 = 1; req_a0 = tbl[v].a; req_b0 = tbl[v].b; req_tag0 = tbl[v].tag;
            chk("tbl_req_ready", 64'(req_ready0), 64'd1);
            @(negedge clk);
            req_valid0 = 0;
            chk("tbl_mul_a", 64'(mul_a0), 64'(tbl[v].a));
            chk("tbl_mul_b", 64'(mul_b0), 64'(tbl[v].b));
            chk("tbl_not_early", 64'(res_valid0), 64'd0);
            @(negedge clk);
            chk("tbl_res_valid", 64'(res_valid0), 64'd1);
            chk("tbl_res_o",     64'(res_o0),     64'(tbl[v].res));
            chk("tbl_res_tag",   64'(res_tag0),   64'(tbl[v].tag));
            @(negedge clk);
            chk("tbl_popped", 64'(res_valid0), 64'd0);
        end
        res_ready0 = 0;

        // ---- special values ----
`ifdef FPU_F32_MUL_SPECIAL_BYPASS_EN
        issue0(32'h7F80_0000, 32'h0000_0000, 4'd8, "inf_x_zero");
        pop0_expect(32'h7FC0_0000, 4'd8, "inf_x_zero");
        issue0(32'h8000_0000, 32'h3F80_0000, 4'd9, "negzero_x_one");
        pop0_expect(32'h8000_0000, 4'd9, "negzero_x_one");
        issue0(32'h7FC0_0001, 32'h3F80_0000, 4'd10, "nan_x_one");
        pop0_expect(32'h7FC0_0000, 4'd10, "nan_x_one");
        issue0(32'h7F80_0000, 32'hBF80_0000, 4'd11, "inf_x_negone");
        pop0_expect(32'hFF80_0000, 4'd11, "inf_x_negone");
`else
        force0 = 1;
        issue0(32'h3F80_0000, 32'h3F80_0000, 4'd7, "forced_mul_o");
        pop0_expect(32'h1234_5678, 4'd7, "forced_mul_o");
        force0 = 0;
        issue0(32'h7F80_0000, 32'h4000_0000, 4'd6, "no_bypass_inf");
        pop0_expect(f32_mul(32'h7F80_0000, 32'h4000_0000), 4'd6, "no_bypass_inf");
`endif

        // ---- back-pressure: fill 4, hold 5th, pop one, 5th accepted ----
        res_ready0 = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid0 = 1; req_a0 = int_f32(i + 1); req_b0 = int_f32(2); req_tag0 = 4'(i + 1);
            chk("bp_ready", 64'(req_ready0), 64'd1);
            @(negedge clk);
        end
        req_a0 = int_f32(5); req_b0 = int_f32(2); req_tag0 = 4'd5;
        chk("bp_full", 64'(req_ready0), 64'd0);
        @(negedge clk);
        chk("bp_hold", 64'(req_ready0), 64'd0);
        chk("bp_head_tag", 64'(res_tag0), 64'd1);
        chk("bp_head_o", 64'(res_o0), 64'(int_f32(2)));
        res_ready0 = 1;
        @(negedge clk);
        res_ready0 = 0;
        chk("bp_reopen", 64'(req_ready0), 64'd1);
        @(negedge clk);
        req_valid0 = 0;
        chk("bp_refull", 64'(req_ready0), 64'd0);
        for (int i = 1; i < 5; i++)
            pop0_expect(int_f32(2 * (i + 1)), 4'(i + 1), "bp_drain");
        chk("bp_empty", 64'(res_valid0), 64'd0);

        // ---- reset mid-operation on LATENCY=2: one buffered, two in flight ----
        res_ready2 = 0;
        for (int i = 0; i < 3; i++) begin
            req_valid2 = 1; req_a2 = int_f32(7); req_b2 = int_f32(7); req_tag2 = 4'(10 + i);
            @(negedge clk);
        end
        req_valid2 = 0;
        @(negedge clk);
        chk("mid_buffered", 64'(res_valid2), 64'd1);
        chk("mid_head_tag", 64'(res_tag2), 64'd10);
        n_rst = 0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready2), 64'd0);
        n_rst = 1;
        @(negedge clk);
        chk("mid_rel_ready", 64'(req_ready2), 64'd1);
        chk("mid_rel_valid", 64'(res_valid2), 64'd0);
        chk("mid_rel_o",     64'(res_o2),     64'd0);
        chk("mid_rel_tag",   64'(res_tag2),   64'd0);
        chk("mid_rel_mul_a", 64'(mul_a2),     64'd0);
        stale = 0;
        res_ready2 = 1;
        repeat (6) begin
            @(negedge clk);
            if (res_valid2) stale++;
        end
        res_ready2 = 0;
        chk("mid_no_stale", 64'(stale), 64'd0);

        // ---- LATENCY=2: fill 4 from empty, then stream tags 4..15 ----
        for (int i = 0; i < 4; i++) begin
            req_valid2 = 1; req_a2 = int_f32(i + 1); req_b2 = int_f32(3); req_tag2 = 4'(i);
            chk("l2_fill_ready", 64'(req_ready2), 64'd1);
            @(negedge clk);
        end
        req_valid2 = 0;
        chk("l2_full", 64'(req_ready2), 64'd0);

        got = 0;
        fork
            begin
                int t;
                int n;
                t = 4;
                n = 0;
                while (t < 16 && n < 600) begin
                    req_valid2 = 1; req_a2 = int_f32(t + 1); req_b2 = int_f32(3); req_tag2 = 4'(t);
                    if (req_ready2) t++;
                    @(negedge clk);
                    n++;
                end
                req_valid2 = 0;
            end
            begin
                int n;
                n = 0;
                while (got < 16 && n < 600) begin
                    res_ready2 = ($urandom_range(0, 3) != 0);
                    if (res_valid2 && res_ready2) begin
                        chk("stream_tag", 64'(res_tag2), 64'(got));
                        chk("stream_o",   64'(res_o2),   64'(int_f32((got + 1) * 3)));
                        got++;
                    end
                    @(negedge clk);
                    n++;
                end
                res_ready2 = 0;
            end
        join
        chk("stream_count", 64'(got), 64'd16);
        repeat (5) @(negedge clk);
        chk("stream_no_dup", 64'(res_valid2), 64'd0);
        chk("stream_ready",  64'(req_ready2), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
